// File: rtl/pipe_ctrl_unit.sv
// Pipeline controller for the 5-stage core: opcode decode, ID/EX/MEM/WB control
// pipe, load-use/RAW hazard stall, branch/jump flush, forwarding selects, event counters.
module pipe_ctrl_unit #(
    parameter int OPC_W  = 5,
    parameter int CTRL_W = 12,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  opcode_id,
    input  logic [RA_W-1:0]   rs1_id,
    input  logic [RA_W-1:0]   rs2_id,
    input  logic [RA_W-1:0]   rd_id,
    input  logic              br_taken_ex,
    output logic [CTRL_W-1:0] ctrl_id,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [CTRL_W-1:0] ctrl_mem,
    output logic [CTRL_W-1:0] ctrl_wb,
    output logic [RA_W-1:0]   rd_wb,
    output logic              illegal_id,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [11:0]     dec;
    logic            opc_hi_nz;
    logic [RA_W-1:0] rs1_ex, rs2_ex, rd_ex, rd_mem;
    logic [2:0]      addrsel_ex;
    logic            raw_hz;

    function automatic logic hit(input logic [RA_W-1:0] rd,
                                 input logic [RA_W-1:0] ra,
                                 input logic [RA_W-1:0] rb);
        return (rd != '0) && ((rd == ra) || (rd == rb));
    endfunction

    // EX/MEM result is the youngest, so it is checked before MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic            we_mem,
                                           input logic [RA_W-1:0] rdm,
                                           input logic            we_wb,
                                           input logic [RA_W-1:0] rdw);
        if (FWD_EN == 0 || rs == '0) return 2'b00;
        if (we_mem && rdm == rs)     return 2'b01;
        if (we_wb && rdw == rs)      return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        dec        = '0;
        illegal_id = 1'b0;
        opc_hi_nz  = (opcode_id >> 5) != '0;
        if (opc_hi_nz) begin
            illegal_id = 1'b1;
        end else begin
            case (opcode_id[4:0])
                5'h01: dec = 12'h803;
                5'h02: dec = 12'h802;
                5'h03: dec = 12'h805;
                5'h04: dec = 12'h807;
                5'h05: dec = 12'h806;
                5'h06: dec = 12'h809;
                5'h07: dec = 12'h808;
                5'h08: dec = 12'h80B;
                5'h09: dec = 12'h80A;
                5'h0A: dec = 12'h80D;
                5'h0B: dec = 12'h80C;
                5'h0C: dec = 12'h80F;
                5'h0D: dec = 12'h80E;
                5'h0E: dec = 12'hA00;
                5'h0F: dec = 12'hD02;
                5'h10: dec = 12'h082;
                5'h11: dec = 12'h015;
                5'h12: dec = 12'h025;
                5'h13: dec = 12'hE30;
                5'h14: dec = 12'hE42;
                default: illegal_id = 1'b1;
            endcase
        end
        ctrl_id        = '0;
        ctrl_id[11:0]  = dec;
    end

    always_comb begin
        addrsel_ex = ctrl_ex[6:4];
        flush = (((addrsel_ex == 3'd1) || (addrsel_ex == 3'd2)) && br_taken_ex) ||
                (addrsel_ex == 3'd3) || (addrsel_ex == 3'd4);
        if (FWD_EN != 0)
            raw_hz = ctrl_ex[8] && hit(rd_ex, rs1_id, rs2_id);
        else
            raw_hz = (ctrl_ex[11]  && hit(rd_ex,  rs1_id, rs2_id)) ||
                     (ctrl_mem[11] && hit(rd_mem, rs1_id, rs2_id)) ||
                     (ctrl_wb[11]  && hit(rd_wb,  rs1_id, rs2_id));
        stall = raw_hz && !flush;
        fwd_a = fwd_sel(rs1_ex, ctrl_mem[11], rd_mem, ctrl_wb[11], rd_wb);
        fwd_b = fwd_sel(rs2_ex, ctrl_mem[11], rd_mem, ctrl_wb[11], rd_wb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ex   <= '0;
            ctrl_mem  <= '0;
            ctrl_wb   <= '0;
            rs1_ex    <= '0;
            rs2_ex    <= '0;
            rd_ex     <= '0;
            rd_mem    <= '0;
            rd_wb     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall || flush) begin
                ctrl_ex <= '0;
                rs1_ex  <= '0;
                rs2_ex  <= '0;
                rd_ex   <= '0;
            end else begin
                ctrl_ex <= ctrl_id;
                rs1_ex  <= rs1_id;
                rs2_ex  <= rs2_id;
                rd_ex   <= rd_id;
            end
            ctrl_mem <= ctrl_ex;
            rd_mem   <= rd_ex;
            ctrl_wb  <= ctrl_mem;
            rd_wb    <= rd_mem;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: forwarding instance (CNT_W=16) and stall-only instance (CNT_W=2)
// driven by the same ID-stage stimulus.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  opcode_id = '0;
    logic [4:0]  rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic        br_taken_ex = 1'b0;

    logic [11:0] ctrl_id0, ctrl_ex0, ctrl_mem0, ctrl_wb0;
    logic [4:0]  rd_wb0;
    logic        illegal_id0, stall0, flush0;
    logic [1:0]  fwd_a0, fwd_b0;
    logic [15:0] stall_cnt0, flush_cnt0;

    logic [11:0] ctrl_id1, ctrl_ex1, ctrl_mem1, ctrl_wb1;
    logic [4:0]  rd_wb1;
    logic        illegal_id1, stall1, flush1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [1:0]  stall_cnt1, flush_cnt1;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [11:0] tab [32];
    logic [11:0] wb_q [$];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.OPC_W(5), .CTRL_W(12), .RA_W(5), .FWD_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .br_taken_ex(br_taken_ex), .ctrl_id(ctrl_id0), .ctrl_ex(ctrl_ex0),
        .ctrl_mem(ctrl_mem0), .ctrl_wb(ctrl_wb0), .rd_wb(rd_wb0), .illegal_id(illegal_id0),
        .stall(stall0), .flush(flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipe_ctrl_unit #(.OPC_W(5), .CTRL_W(12), .RA_W(5), .FWD_EN(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .br_taken_ex(br_taken_ex), .ctrl_id(ctrl_id1), .ctrl_ex(ctrl_ex1),
        .ctrl_mem(ctrl_mem1), .ctrl_wb(ctrl_wb1), .rd_wb(rd_wb1), .illegal_id(illegal_id1),
        .stall(stall1), .flush(flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic br);
        opcode_id   = op;
        rs1_id      = r1;
        rs2_id      = r2;
        rd_id       = rd;
        br_taken_ex = br;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] op;
        logic [11:0] exp_w;
        tab = '{12'h000, 12'h803, 12'h802, 12'h805, 12'h807, 12'h806, 12'h809, 12'h808,
                12'h80B, 12'h80A, 12'h80D, 12'h80C, 12'h80F, 12'h80E, 12'hA00, 12'hD02,
                12'h082, 12'h015, 12'h025, 12'hE30, 12'hE42, 12'h000, 12'h000, 12'h000,
                12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({ctrl_ex0, ctrl_mem0, ctrl_wb0}), 0);
        check("rst_misc", 32'({rd_wb0, stall0, flush0, fwd_a0, fwd_b0}), 0);
        check("rst_cnt", 32'({stall_cnt0, flush_cnt0}), 0);
        rst_n = 1'b1;

        // opcode sweep with a bubble after each opcode; ctrl_wb scoreboard
        do_reset();
        for (int unsigned k = 0; k < 66; k++) begin
            op = (k < 64 && (k % 2) == 0) ? 5'(k / 2) : 5'd0;
            drive(op, 5'd0, 5'd0, 5'd0, 1'b0);
            #1;
            if (k < 64) begin
                check("ctrl_id", 32'(ctrl_id0), 32'(tab[op]));
                check("illegal_id", 32'(illegal_id0), 32'(op == 5'd0 || op > 5'd20));
                wb_q.push_back(tab[op]);
            end
            tick();
            check("sweep_flush", 32'(flush0), 32'(op == 5'd19 || op == 5'd20));
            check("sweep_stall", 32'(stall0), 0);
            if (k >= 2) begin
                exp_w = wb_q.pop_front();
                check("ctrl_wb", 32'(ctrl_wb0), 32'(exp_w));
            end
        end

        // load-use: lw r5 then add rs1=r5
        do_reset();
        drive(5'h0F, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(5'h01, 5'd5, 5'd6, 5'd8, 1'b0);
        #1 check("lu_stall", 32'(stall0), 1);
        tick();
        check("lu_bubble", 32'(ctrl_ex0), 0);
        check("lu_release", 32'(stall0), 0);
        check("lu_stall_cnt", 32'(stall_cnt0), 1);
        tick();
        check("lu_add_ex", 32'(ctrl_ex0), 'h803);
        check("lu_fwd_a", 32'(fwd_a0), 2);
        check("lu_fwd_b", 32'(fwd_b0), 0);
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // EX/MEM forwarding and EX/MEM-over-MEM/WB priority
        do_reset();
        drive(5'h01, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(5'h03, 5'd4, 5'd3, 5'd9, 1'b0);
        #1 check("raw_no_stall", 32'(stall0), 0);
        tick();
        check("fwd_b_mem", 32'(fwd_b0), 1);
        check("fwd_a_none", 32'(fwd_a0), 0);
        drive(5'h01, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(5'h01, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(5'h03, 5'd0, 5'd3, 5'd9, 1'b0);
        tick();
        check("fwd_b_prio", 32'(fwd_b0), 1);
        check("fwd_a_r0", 32'(fwd_a0), 0);
        drive(5'h01, 5'd1, 5'd2, 5'd4, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(5'h03, 5'd4, 5'd0, 5'd9, 1'b0);
        tick();
        check("fwd_a_wb", 32'(fwd_a0), 2);

        // taken beq in EX with a RAW hazard in ID: flush wins
        do_reset();
        drive(5'h0F, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(5'h12, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(5'h01, 5'd5, 5'd6, 5'd8, 1'b1);
        #1;
        check("br_flush0", 32'(flush0), 1);
        check("br_stall0", 32'(stall0), 0);
        check("br_flush1", 32'(flush1), 1);
        check("br_stall1", 32'(stall1), 0);
        tick();
        check("br_flush_cnt0", 32'(flush_cnt0), 1);
        check("br_flush_cnt1", 32'(flush_cnt1), 1);
        check("br_stall_cnt1", 32'(stall_cnt1), 0);
        check("br_bubble", 32'(ctrl_ex0), 0);
        check("br_flush_off", 32'(flush0), 0);
        drive(5'h12, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 check("beq_not_taken", 32'(flush0), 0);
        tick();
        drive(5'h11, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        #1 check("blt_taken", 32'(flush0), 1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // no forwarding: RAW resolved by stalling through WB
        do_reset();
        drive(5'h01, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        drive(5'h06, 5'd7, 5'd0, 5'd9, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            check("nf_stall", 32'(stall1), 1);
            check("nf_fwd", 32'({fwd_a1, fwd_b1}), 0);
            tick();
        end
        check("nf_release", 32'(stall1), 0);
        check("nf_stall_cnt", 32'(stall_cnt1), 3);
        tick();
        check("nf_or_ex", 32'(ctrl_ex1), 'h809);
        drive(5'h01, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(5'h06, 5'd0, 5'd0, 5'd9, 1'b0);
        #1 check("nf_rd0", 32'(stall1), 0);
        tick();

        // counter saturation, then reset mid-stall
        drive(5'h01, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        drive(5'h06, 5'd7, 5'd0, 5'd9, 1'b0);
        tick();
        #1 check("sat_stall", 32'(stall1), 1);
        tick();
        check("sat_cnt", 32'(stall_cnt1), 3);
        #1 check("mid_stall", 32'(stall1), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ctrl", 32'({ctrl_ex1, ctrl_mem1, ctrl_wb1}), 0);
        check("arst_misc", 32'({rd_wb1, stall1, flush1, fwd_a1, fwd_b1}), 0);
        check("arst_cnt", 32'({stall_cnt1, flush_cnt1}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_stall", 32'(stall1), 0);
        tick();
        check("post_rst_decode", 32'(ctrl_ex1), 'h809);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
